// File: rtl/obi_mem_responder_pkg.sv
// Shared types for the OBI scratchpad responder: bus widths and the response record.
package obi_mem_responder_pkg;

    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/obi_mem_responder_resp_pipe.sv
// Fixed-latency response delay line; every stage clears to zero so idle outputs stay 0.
module obi_mem_responder_resp_pipe
    import obi_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic     clk,
    input  logic     n_reset,
    input  obi_rsp_t rsp_in,
    output obi_rsp_t rsp_out
);

    obi_rsp_t stage [LATENCY];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= rsp_in;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rsp_out = stage[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// Word-addressed OBI responder memory with fixed read latency, bounded outstanding
// requests and a stall input that blocks grants for back-pressure testing.
module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [OBI_BE_W-1:0]   data_be_i,
    input  logic [OBI_DATA_W-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [OBI_DATA_W-1:0] data_rdata_o,
    output logic                  data_err_o,
    input  logic                  stall_i
);

    localparam int unsigned     DEPTH   = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [OBI_DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      outstanding;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic                  in_range;
    logic                  accept;
    obi_rsp_t              rsp_in;
    obi_rsp_t              rsp_out;

    // Unsigned wrap makes addresses below BASE_ADDR decode as out of range.
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < (33'd1 << ADDR_WIDTH);
    assign word_idx = offset[ADDR_WIDTH-1:2];

    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign data_gnt_o = n_reset & data_req_i & ~stall_i &
                        ((outstanding < CNT_MAX) | data_rvalid_o);
    assign accept     = data_req_i & data_gnt_o;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            outstanding <= '0;
        end else if (accept && !data_rvalid_o) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && data_rvalid_o) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    // Memory is deliberately not reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < OBI_BE_W; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_in       = '0;
        rsp_in.valid = accept;
        rsp_in.err   = accept & ~in_range;
        if (accept && in_range && !data_we_i) begin
            rsp_in.rdata = mem[word_idx];
        end
    end

    obi_mem_responder_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .n_reset (n_reset),
        .rsp_in  (rsp_in),
        .rsp_out (rsp_out)
    );

    assign data_rvalid_o = rsp_out.valid;
    assign data_err_o    = rsp_out.err;
    assign data_rdata_o  = rsp_out.rdata;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder across three latency/outstanding configurations.
module tb_obi_mem_responder;

    localparam logic [31:0] BASE2 = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  n_reset = '0;
    logic [2:0]  req     = '0;
    logic [2:0]  we      = '0;
    logic [2:0]  stall   = '0;
    logic [2:0]  gnt, rvalid, err;
    logic [31:0] addr  [3] = '{default: '0};
    logic [31:0] wdata [3] = '{default: '0};
    logic [3:0]  be    [3] = '{default: '0};
    logic [31:0] rdata [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    obi_mem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(1)) dut0 (
        .clk(clk), .n_reset(n_reset[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
        .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]), .stall_i(stall[0]));

    obi_mem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(2), .MAX_OUTSTANDING(1)) dut1 (
        .clk(clk), .n_reset(n_reset[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]), .stall_i(stall[1]));

    obi_mem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(BASE2), .LATENCY(3), .MAX_OUTSTANDING(3)) dut2 (
        .clk(clk), .n_reset(n_reset[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_addr_i(addr[2]), .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i(wdata[2]),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]), .stall_i(stall[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e);
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp_v);
        end
    endtask

    // Monitor: every response is popped and compared, including its arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rvalid[d]) begin
                if (q_size(d) == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid dut%0d cycle=%0d", d, cyc);
                end else begin
                    pop_exp(d, e);
                    if (rdata[d] !== e.rdata || err[d] !== e.err || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL rsp dut%0d got rdata=%h err=%b cycle=%0d required rdata=%h err=%b cycle=%0d",
                                 d, rdata[d], err[d], cyc, e.rdata, e.err, e.cyc);
                    end
                end
            end else if (rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero dut%0d got rdata=%h err=%b required 0/0", d, rdata[d], err[d]);
            end
        end
    end

    // Starts and ends on a falling edge; holds the request until granted.
    task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input bit expect_rsp, output int acc_cyc);
        int   waited = 0;
        exp_t e;
        req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
        #1;
        while (!gnt[d] && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        acc_cyc = cyc;
        checks++;
        if (!gnt[d]) begin
            errors++;
            $display("FAIL grant_timeout dut%0d addr=%h got no grant required grant", d, a);
            acc_cyc = -1;
        end else if (expect_rsp) begin
            e.rdata = er; e.err = ee; e.cyc = cyc + lat_of(d);
            push_exp(d, e);
        end
        @(negedge clk);
        req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; wdata[d] = 32'h0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input logic ee);
        int c;
        issue(d, a, 1'b1, b, wd, 32'h0, ee, 1'b1, c);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] er, input logic ee);
        int c;
        issue(d, a, 1'b0, 4'h0, 32'h0, er, ee, 1'b1, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c_prev, first, last;

        // Reset state with requests asserted
        @(negedge clk);
        req = 3'b111;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_gnt_dut%0d", d), {31'h0, gnt[d]}, 32'h0);
            check($sformatf("reset_rvalid_dut%0d", d), {31'h0, rvalid[d]}, 32'h0);
        end
        @(negedge clk);
        req = '0;
        n_reset = 3'b111;
        @(negedge clk);

        // dut0, latency 1: write/readback, byte merge, range boundary
        wr(0, 32'h010, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        rd(0, 32'h010, 32'hDEAD_BEEF, 1'b0);
        wr(0, 32'h020, 32'h1122_3344, 4'b1111, 1'b0);
        wr(0, 32'h020, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd(0, 32'h020, 32'h11BB_33DD, 1'b0);
        wr(0, 32'h000, 32'h5A5A_0000, 4'b1111, 1'b0);
        wr(0, 32'hFFC, 32'h0FFC_0FFC, 4'b1111, 1'b0);
        wr(0, 32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        rd(0, 32'h1000, 32'h0, 1'b1);
        rd(0, 32'hFFC, 32'h0FFC_0FFC, 1'b0);
        rd(0, 32'h000, 32'h5A5A_0000, 1'b0);

        // dut1, latency 2 / one outstanding: grant spacing and stall
        for (int i = 0; i < 4; i++) wr(1, 32'(4 * i), 32'hA000_0000 + 32'(i), 4'b1111, 1'b0);
        c_prev = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1, 32'(4 * i), 1'b0, 4'h0, 32'h0, 32'hA000_0000 + 32'(i), 1'b0, 1'b1, c);
            if (i > 0) check($sformatf("grant_spacing_%0d", i), 32'(c - c_prev), 32'd2);
            c_prev = c;
        end
        issue(1, 32'h000, 1'b0, 4'h0, 32'h0, 32'hA000_0000, 1'b0, 1'b1, c_prev);
        stall[1] = 1'b1;
        req[1] = 1'b1; addr[1] = 32'h004; we[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_no_gnt_%0d", i), {31'h0, gnt[1]}, 32'h0);
            @(negedge clk);
        end
        stall[1] = 1'b0;
        issue(1, 32'h004, 1'b0, 4'h0, 32'h0, 32'hA000_0001, 1'b0, 1'b1, c);
        check("gnt_after_stall_cycle", 32'(c - c_prev), 32'd4);

        // dut2, latency 3 / three outstanding, nonzero base: throughput
        for (int i = 0; i < 8; i++) wr(2, BASE2 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'b1111, 1'b0);
        first = 0; last = 0;
        for (int i = 0; i < 8; i++) begin
            issue(2, BASE2 + 32'(4 * i), 1'b0, 4'h0, 32'h0, 32'hB000_0000 + 32'(i), 1'b0, 1'b1, c);
            if (i == 0) first = c;
            last = c;
        end
        check("eight_grants_span", 32'(last - first), 32'd7);
        rd(2, BASE2 - 32'd4, 32'h0, 1'b1);
        rd(2, BASE2 + 32'h1000, 32'h0, 1'b1);
        wr(2, BASE2 + 32'hFFC, 32'h1234_5678, 4'b1111, 1'b0);
        rd(2, BASE2 + 32'hFFC, 32'h1234_5678, 1'b0);

        // dut2: reset while a read is in flight
        wr(2, BASE2 + 32'h040, 32'hCAFE_0042, 4'b1111, 1'b0);
        idle(5);
        issue(2, BASE2 + 32'h040, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, c);
        n_reset[2] = 1'b0;
        req[2] = 1'b1;
        #1;
        check("gnt_in_reset", {31'h0, gnt[2]}, 32'h0);
        @(negedge clk);
        req[2] = 1'b0;
        n_reset[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("no_rvalid_after_reset_%0d", i), {31'h0, rvalid[2]}, 32'h0);
            @(negedge clk);
        end
        rd(2, BASE2 + 32'h040, 32'hCAFE_0042, 1'b0);

        idle(8);
        for (int d = 0; d < 3; d++) check($sformatf("drained_dut%0d", d), 32'(q_size(d)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- Synthesizable word-addressed memory that acts as the OBI responder (slave) for the vector LSU's data master port.
- Accepts read/write requests with byte enables and returns one in-order response per accepted request after a fixed LATENCY.
- Used as the accelerator's local scratchpad and as the bench-side memory for LSU verification.
- A stall input throttles grants so back-pressure can be exercised.

Parameters:
- ADDR_WIDTH, 12: byte-address bits of the window. Depth is 2^(ADDR_WIDTH-2) 32-bit words.
- BASE_ADDR, 32'h0000_0000: window base. Must be aligned to 2^ADDR_WIDTH.
- LATENCY, 1: cycles from acceptance to rvalid. Legal range 1..4.
- MAX_OUTSTANDING, 1: maximum accepted-but-unanswered requests. Legal range 1..LATENCY.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- n_reset  in  1  asynchronous active-low reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  grant (combinational)
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables for writes
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid, one cycle per response
- data_rdata_o  out  32  read data
- data_err_o  out  1  error flag, qualified by rvalid
- stall_i  in  1  when high, data_gnt_o is forced low

Behaviour:
- Reset values:
  - data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0.
  - Outstanding counter = 0; all response pipeline stages invalid.
  - data_gnt_o = 0 while n_reset is low.
  - Memory array is not reset; contents are undefined until written.
- Grant: data_gnt_o = data_req_i & ~stall_i & (outstanding < MAX_OUTSTANDING | data_rvalid_o). A retiring response frees a slot in the same cycle.
- Acceptance: a request is accepted in the cycle where data_req_i & data_gnt_o is high. Address, we, be and wdata are sampled at that edge only. The master may change them freely when not granted.
- Address decode:
  - in_range = (data_addr_i - BASE_ADDR) < 2^ADDR_WIDTH, using unsigned 32-bit arithmetic.
  - Word index = offset[ADDR_WIDTH-1:2].
- Accepted write, in range:
  - Bytes with be[i]=1 are updated at the acceptance edge.
  - Response has rdata = 0 and err = 0.
- Accepted read, in range:
  - The whole word is read at the acceptance edge, ignoring be.
  - The read observes all writes accepted in earlier cycles.
- Out of range, read or write:
  - No memory update.
  - Response has rdata = 0 and err = 1.
- Latency: a request accepted in cycle N produces data_rvalid_o = 1 in cycle N+LATENCY, with its rdata/err valid in that same cycle.
- Responses are strictly in order. No response is generated without a prior acceptance.
- Outstanding counter:
  - next = count + accept - data_rvalid_o.
  - Width is clog2(MAX_OUTSTANDING+1).
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Back-to-back operation: with MAX_OUTSTANDING = LATENCY, one acceptance per cycle is sustained indefinitely.
- Simultaneous accept and retire in one cycle: the counter is unchanged.
- stall_i:
  - Affects only grant; responses already in flight still complete on schedule.
  - A master holding req through a stall is granted in the first cycle after stall_i falls.
- Reset mid-operation:
  - In-flight responses are discarded and no rvalid follows.
  - Writes accepted before reset remain in memory.
- data_rdata_o and data_err_o hold 0 in cycles where data_rvalid_o = 0.

Decomposition:
- accelerator_pkg gains:
  - OBI_DATA_W = 32, OBI_BE_W = 4.
  - typedef obi_rsp_t {logic valid; logic err; logic [31:0] rdata;}.
- Sub-module obi_resp_pipe:
  - A LATENCY-deep shift register of obi_rsp_t with asynchronous active-low reset, clearing valid.
  - The top level holds the memory array, decode, grant logic and outstanding counter.

Test Plan:
- Write then read back: write 32'hDEAD_BEEF to 0x010 with be=4'b1111, then read 0x010 → two rvalid pulses, each exactly LATENCY cycles after its grant; second rdata = 32'hDEAD_BEEF, err = 0.
- Byte-enable merge: write 32'h1122_3344 to 0x020 (be=1111), write 32'hAABB_CCDD (be=0101), then read 0x020 → rdata = 32'h11BB_33DD.
- Out of range (ADDR_WIDTH=12, BASE=0): write to 0x1000, then read 0x1000 and 0x0FFC → first two responses have err = 1 and rdata = 0; the read of 0x0FFC has err = 0; memory at 0x000 is unchanged.
- Stall and back-pressure: LATENCY=2, MAX_OUTSTANDING=1, req held for 4 reads of 0x000..0x00C → grants spaced every 2 cycles. Then stall_i = 1 for 3 cycles → no grant during the stall; the in-flight response still arrives.
- Pipelined throughput: LATENCY=3, MAX_OUTSTANDING=3, 8 consecutive reads → 8 grants in 8 cycles, rvalid high in cycles 3..10, data in address order.
- Reset mid-flight: LATENCY=3, accept a read, assert n_reset low 1 cycle later → rvalid never rises. After reset release, a read of a previously written address returns the data written before reset.
